// File: rtl/adc_quantizer_pkg.sv
// Helpers shared by the ADC quantizer slice: statistics counter type and a
// saturating increment used by the optional counters (ADC_SAT_COUNT_EN).
package adc_quantizer_pkg;

    localparam int unsigned CNT_BITS = 32;

    typedef logic [CNT_BITS-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    // Increment by one when bump is set, sticking at the all-ones value.
    function automatic cnt_t sat_inc(input cnt_t value, input logic bump);
        cnt_t result;
        result = value;
        if (bump && (value != CNT_MAX)) begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage : adc_quantizer_pkg

// File: rtl/time_package.sv
// Shared emulation-time definitions used by every timestamped block.
// TIME_FORMAT is an unsigned fixed-point time value with TIME_POINT
// fractional bits.
package time_package;

    typedef logic [47:0] TIME_FORMAT;
    localparam int TIME_POINT = 16;

endpackage : time_package

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides and an occupancy output.
//
// Handshake: a side transfers on a posedge where its valid and ready are both
// 1. pop_valid is 1 whenever the FIFO holds data and pop_data is the head
// entry. push_ready is 1 when there is a free slot, or when the FIFO is full
// but the head is being popped on the same edge, so a full FIFO can accept
// and release an entry together with the level unchanged.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [width-1:0]         push_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [width-1:0]         pop_data,
    output logic [$clog2(depth):0]   level
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             push;
    logic             pop;

    assign full       = (count == DEPTH_CNT);
    assign pop_valid  = (count != '0);
    assign pop        = pop_valid && pop_ready;
    assign push_ready = !full || pop;
    assign push       = push_valid && push_ready;
    assign pop_data   = mem[rd_ptr];
    assign level      = count;

    // Storage write; contents need no reset because pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks pushes minus pops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/adc_quantizer.sv
// ADC quantizer: captures a signed fixed-point sample with its timestamp,
// rounds half-up to a narrower code, saturates, and queues the result in a
// sync_fifo towards a valid/ready consumer. A sample arriving while the FIFO
// is full and not draining is discarded and flagged on drop.
//
// Optional feature: define ADC_SAT_COUNT_EN to add the 32-bit saturating
// statistics outputs sat_count (results clamped to either rail) and
// drop_count (discarded samples).
//
// Pipeline: samp_en edge -> stage 1 capture -> stage 2 round/saturate
// register -> FIFO push on the next edge; out_valid rises two edges after
// the strobe. A strobe whose time_curr carries X/Z is ignored.
module adc_quantizer
    import time_package::*;
    import adc_quantizer_pkg::*;
#(
    parameter int sig_bits   = 16,
    parameter int sig_point  = 14,
    parameter int out_bits   = 8,
    parameter int out_point  = 6,
    parameter int fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  TIME_FORMAT                    time_curr,
    input  logic signed [sig_bits-1:0]    sig,
    input  logic                          samp_en,
    output logic [out_bits-1:0]           code,
    output TIME_FORMAT                    time_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          drop,
    output logic [$clog2(fifo_depth):0]   fifo_level
`ifdef ADC_SAT_COUNT_EN
    ,
    output logic [31:0]                   sat_count,
    output logic [31:0]                   drop_count
`endif
);

    localparam int SH = sig_point - out_point;
    localparam int W1 = sig_bits + 1;
    localparam int TW = $bits(TIME_FORMAT);
    localparam int FW = out_bits + TW;

    localparam logic signed [W1-1:0] HALF     = W1'(1) << (SH - 1);
    localparam logic signed [W1-1:0] MAX_CODE = W1'((1 << (out_bits - 1)) - 1);
    localparam logic signed [W1-1:0] MIN_CODE = W1'(-(1 << (out_bits - 1)));

    // Stage 1: raw captured sample.
    logic                       s1_valid;
    logic signed [sig_bits-1:0] s1_sig;
    TIME_FORMAT                 s1_time;
    logic                       capture;

    // Stage 2: quantized, saturated code awaiting the FIFO.
    logic                       s2_valid;
    logic [out_bits-1:0]        s2_code;
    TIME_FORMAT                 s2_time;

    // Round/saturate datapath.
    logic signed [W1-1:0]       widened;
    logic signed [W1-1:0]       rounded;
    logic signed [W1-1:0]       shifted;
    logic [out_bits-1:0]        code_next;

    // FIFO side.
    logic                       push_ready;
    logic                       head_valid;
    logic [FW-1:0]              head_data;

    // Timestamps with unknown bits are not trusted, so such strobes are ignored.
    assign capture = samp_en && !$isunknown(time_curr);

    // Stage 1 capture of sample and timestamp on the strobe edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sig   <= '0;
            s1_time  <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_sig  <= sig;
                s1_time <= time_curr;
            end
        end
    end

    // Round half-up in one extra bit so adding HALF cannot wrap, then clamp to the code range.
    always_comb begin
        widened   = {s1_sig[sig_bits-1], s1_sig};
        rounded   = widened + HALF;
        shifted   = rounded >>> SH;
        code_next = shifted[out_bits-1:0];
        if (shifted > MAX_CODE) begin
            code_next = MAX_CODE[out_bits-1:0];
        end else if (shifted < MIN_CODE) begin
            code_next = MIN_CODE[out_bits-1:0];
        end
    end

    // Stage 2 register holds the quantized code with its timestamp until the push edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_code  <= '0;
            s2_time  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_code <= code_next;
                s2_time <= s1_time;
            end
        end
    end

    sync_fifo #(
        .width (FW),
        .depth (fifo_depth)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (s2_valid),
        .push_ready (push_ready),
        .push_data  ({s2_code, s2_time}),
        .pop_valid  (head_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_data),
        .level      (fifo_level)
    );

    // Outputs read zero whenever nothing is presented, including after reset.
    assign out_valid = head_valid;
    assign code      = head_valid ? head_data[FW-1 -: out_bits] : '0;
    assign time_out  = head_valid ? head_data[TW-1:0] : '0;

    // One-cycle drop pulse when a stage-2 result finds the FIFO full and not draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop <= 1'b0;
        end else begin
            drop <= s2_valid && !push_ready;
        end
    end

`ifdef ADC_SAT_COUNT_EN
    logic rail_hit;

    // A result counts as saturated when it lands on either rail of the code range.
    assign rail_hit = (code_next == MAX_CODE[out_bits-1:0]) ||
                      (code_next == MIN_CODE[out_bits-1:0]);

    // Statistics counters, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count  <= '0;
            drop_count <= '0;
        end else begin
            sat_count  <= sat_inc(sat_count, s1_valid && rail_hit);
            drop_count <= sat_inc(drop_count, s2_valid && !push_ready);
        end
    end
`endif

endmodule : adc_quantizer

// File: tb/tb_adc_quantizer.sv
// Self-checking bench for adc_quantizer with a reference model built from
// the quantization and buffering rules (real-valued rounding, queues).
`timescale 1ns/1ps
module tb_adc_quantizer;
    import time_package::*;

    localparam int SIG_BITS  = 16;
    localparam int SIG_POINT = 14;
    localparam int OUT_BITS  = 8;
    localparam int OUT_POINT = 6;
    localparam int DEPTH     = 4;
    localparam int TW        = $bits(TIME_FORMAT);
    localparam int W         = OUT_BITS + TW;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    TIME_FORMAT                 time_curr;
    logic signed [SIG_BITS-1:0] sig;
    logic                       samp_en;
    logic                       out_ready;
    logic [OUT_BITS-1:0]        code;
    TIME_FORMAT                 time_out;
    logic                       out_valid;
    logic                       drop;
    logic [LW-1:0]              fifo_level;
`ifdef ADC_SAT_COUNT_EN
    logic [31:0]                sat_count;
    logic [31:0]                drop_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    typedef struct {
        int            due;
        logic [W-1:0]  payload;
    } pend_t;
    pend_t        pend[$];
    logic [W-1:0] exp_q[$];
    logic         m_drop = 1'b0;
    int           edge_cnt = 0;
    int           m_sat_cnt = 0;
    int           m_drop_cnt = 0;

    adc_quantizer #(
        .sig_bits   (SIG_BITS),
        .sig_point  (SIG_POINT),
        .out_bits   (OUT_BITS),
        .out_point  (OUT_POINT),
        .fifo_depth (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_curr  (time_curr),
        .sig        (sig),
        .samp_en    (samp_en),
        .code       (code),
        .time_out   (time_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop       (drop),
        .fifo_level (fifo_level)
`ifdef ADC_SAT_COUNT_EN
        ,
        .sat_count  (sat_count),
        .drop_count (drop_count)
`endif
    );

    // Clock generation.
    always #5 clk = ~clk;

    function automatic TIME_FORMAT rand_time();
        return TIME_FORMAT'({$urandom, $urandom});
    endfunction

    // Value of sig in units of the output LSB, rounded half-up, clamped.
    function automatic int ref_quant(input logic signed [SIG_BITS-1:0] s);
        int  si;
        int  q;
        real scaled;
        si     = s;
        scaled = $itor(si) / (2.0 ** (SIG_POINT - OUT_POINT));
        q      = $rtoi($floor(scaled + 0.5));
        if (q > (1 << (OUT_BITS - 1)) - 1) q = (1 << (OUT_BITS - 1)) - 1;
        if (q < -(1 << (OUT_BITS - 1)))    q = -(1 << (OUT_BITS - 1));
        return q;
    endfunction

    // Advance the model across the coming edge, using the inputs now driven.
    task automatic model_step();
        bit    full_before;
        bit    do_pop;
        int    q;
        pend_t e;
        if (rst_n !== 1'b1) begin
            pend.delete();
            exp_q.delete();
            m_drop     = 1'b0;
            m_sat_cnt  = 0;
            m_drop_cnt = 0;
        end else begin
            full_before = (exp_q.size() == DEPTH);
            do_pop      = (exp_q.size() > 0) && (out_ready === 1'b1);
            m_drop      = 1'b0;
            if (do_pop) void'(exp_q.pop_front());
            if (pend.size() > 0 && pend[0].due == edge_cnt) begin
                if (!full_before || do_pop) begin
                    exp_q.push_back(pend[0].payload);
                end else begin
                    m_drop = 1'b1;
                    m_drop_cnt++;
                end
                void'(pend.pop_front());
            end
            if (samp_en === 1'b1 && !$isunknown(time_curr)) begin
                q = ref_quant(sig);
                if (q == (1 << (OUT_BITS - 1)) - 1 || q == -(1 << (OUT_BITS - 1))) m_sat_cnt++;
                e.due     = edge_cnt + 2;
                e.payload = {OUT_BITS'(q), time_curr};
                pend.push_back(e);
            end
        end
        edge_cnt++;
    endtask

    // One clock: update the model, take the edge, settle past it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        samp_en = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", drop); end
        checks++; if (code !== '0) begin errors++; $display("FAIL reset_code got %0h exp 0", code); end
        checks++; if (time_out !== '0) begin errors++; $display("FAIL reset_time got %0h exp 0", time_out); end
`ifdef ADC_SAT_COUNT_EN
        checks++; if (sat_count !== '0) begin errors++; $display("FAIL reset_sat_count got %0d exp 0", sat_count); end
        checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", drop_count); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    // Single strobes with hand-derived codes; checks latency and timestamp.
    task automatic run_single(input logic signed [SIG_BITS-1:0] v, input logic [OUT_BITS-1:0] exp_code, input string tag);
        TIME_FORMAT t;
        t = rand_time();
        out_ready = 1'b0;
        sig = v;
        time_curr = t;
        samp_en = 1'b1;
        tick();
        samp_en = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b exp 0", tag, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", tag, out_valid); end
        checks++; if (code !== exp_code) begin errors++; $display("FAIL %s_code got %0h exp %0h", tag, code, exp_code); end
        checks++; if (time_out !== t) begin errors++; $display("FAIL %s_time got %0h exp %0h", tag, time_out, t); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL %s_drained got %0d exp 0", tag, fifo_level); end
    endtask

    task automatic test_rounding();
        run_single(16'sh0080, 8'h01, "round_half");
        run_single(16'sh007F, 8'h00, "round_below_half");
        run_single(-16'sh0080, 8'h00, "round_neg_half");
        run_single(-16'sh0081, 8'hFF, "round_neg_below");
        run_single(16'sh4000, 8'h40, "round_one");
    endtask

    task automatic test_saturation();
        run_single(16'sh7FFF, 8'h7F, "sat_pos");
        run_single(-16'sh8000, 8'h80, "sat_neg");
`ifdef ADC_SAT_COUNT_EN
        checks++; if (sat_count !== 32'd2) begin errors++; $display("FAIL sat_count got %0d exp 2", sat_count); end
`endif
    endtask

    task automatic test_overflow();
        logic [OUT_BITS-1:0] exp_c[4];
        TIME_FORMAT          exp_t[4];
        int                  drops;
        drops = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                sig = SIG_BITS'($urandom);
                time_curr = rand_time();
                samp_en = 1'b1;
                if (i < 4) begin
                    exp_c[i] = OUT_BITS'(ref_quant(sig));
                    exp_t[i] = time_curr;
                end
            end else begin
                samp_en = 1'b0;
            end
            tick();
            if (drop === 1'b1) drops++;
            checks++; if (drop !== m_drop) begin errors++; $display("FAIL ovf_drop[%0d] got %b exp %b", i, drop, m_drop); end
        end
        checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
        checks++; if (drops != 2) begin errors++; $display("FAIL ovf_drop_pulses got %0d exp 2", drops); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (code !== exp_c[i]) begin errors++; $display("FAIL ovf_pop_code[%0d] got %0h exp %0h", i, code, exp_c[i]); end
            checks++; if (time_out !== exp_t[i]) begin errors++; $display("FAIL ovf_pop_time[%0d] got %0h exp %0h", i, time_out, exp_t[i]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL ovf_empty got %0d exp 0", fifo_level); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sig = SIG_BITS'($urandom);
            time_curr = rand_time();
            samp_en = 1'b1;
            tick();
        end
        samp_en = 1'b0;
        repeat (2) tick();
        checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL fpp_fill got %0d exp 4", fifo_level); end
        for (int i = 0; i < 14; i++) begin
            samp_en = (i < 12);
            sig = SIG_BITS'($urandom);
            time_curr = rand_time();
            out_ready = (i >= 2);
            tick();
            checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL fpp_level[%0d] got %0d exp 4", i, fifo_level); end
            checks++; if (drop !== 1'b0) begin errors++; $display("FAIL fpp_drop[%0d] got %b exp 0", i, drop); end
            if (exp_q.size() > 0) begin
                checks++; if ({code, time_out} !== exp_q[0]) begin errors++; $display("FAIL fpp_head[%0d] got %0h exp %0h", i, {code, time_out}, exp_q[0]); end
            end
        end
        samp_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL fpp_drain_valid[%0d] got %b", i, out_valid); end
            if (exp_q.size() > 0) begin
                checks++; if ({code, time_out} !== exp_q[0]) begin errors++; $display("FAIL fpp_drain_head[%0d] got %0h exp %0h", i, {code, time_out}, exp_q[0]); end
            end
        end
        out_ready = 1'b0;
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL fpp_empty got %0d exp 0", fifo_level); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sig = SIG_BITS'($urandom);
            time_curr = rand_time();
            samp_en = 1'b1;
            tick();
        end
        samp_en = 1'b0;
        tick();
        checks++; if (fifo_level !== LW'(3)) begin errors++; $display("FAIL rmf_buffered got %0d exp 3", fifo_level); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid got %b exp 0", out_valid); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rmf_level got %0d exp 0", fifo_level); end
        checks++; if (code !== '0) begin errors++; $display("FAIL rmf_code got %0h exp 0", code); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_stale_valid[%0d] got %b exp 0", i, out_valid); end
            checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rmf_stale_level[%0d] got %0d exp 0", i, fifo_level); end
            checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rmf_stale_drop[%0d] got %b exp 0", i, drop); end
        end
    endtask

    task automatic test_x_time();
        logic [LW-1:0] lvl_before;
        logic [LW-1:0] lvl_exp;
        bit            x_seen;
        out_ready = 1'b0;
        lvl_before = fifo_level;
        sig = SIG_BITS'($urandom);
        time_curr = 'x;
        x_seen = $isunknown(time_curr);
        samp_en = 1'b1;
        tick();
        samp_en = 1'b0;
        time_curr = rand_time();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (drop !== 1'b0) begin errors++; $display("FAIL xtime_drop[%0d] got %b exp 0", i, drop); end
        end
        lvl_exp = x_seen ? lvl_before : lvl_before + 1'b1;
        checks++; if (fifo_level !== lvl_exp) begin errors++; $display("FAIL xtime_level got %0d exp %0d", fifo_level, lvl_exp); end
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            samp_en = ($urandom_range(0, 99) < 60);
            out_ready = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       sig = 16'sh7FFF - SIG_BITS'($urandom_range(0, 200));
                1:       sig = -16'sh8000 + SIG_BITS'($urandom_range(0, 200));
                default: sig = SIG_BITS'($urandom);
            endcase
            time_curr = rand_time();
            tick();
            checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, exp_q.size() > 0); end
            checks++; if (fifo_level !== LW'(exp_q.size())) begin errors++; $display("FAIL rnd_level[%0d] got %0d exp %0d", i, fifo_level, exp_q.size()); end
            checks++; if (drop !== m_drop) begin errors++; $display("FAIL rnd_drop[%0d] got %b exp %b", i, drop, m_drop); end
            if (exp_q.size() > 0) begin
                checks++; if ({code, time_out} !== exp_q[0]) begin errors++; $display("FAIL rnd_head[%0d] got %0h exp %0h", i, {code, time_out}, exp_q[0]); end
            end
        end
        samp_en = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rnd_final_level got %0d exp 0", fifo_level); end
`ifdef ADC_SAT_COUNT_EN
        checks++; if (sat_count !== 32'(m_sat_cnt)) begin errors++; $display("FAIL rnd_sat_count got %0d exp %0d", sat_count, m_sat_cnt); end
        checks++; if (drop_count !== 32'(m_drop_cnt)) begin errors++; $display("FAIL rnd_drop_count got %0d exp %0d", drop_count, m_drop_cnt); end
`endif
    endtask

    initial begin
        time_curr = '0;
        sig = '0;
        samp_en = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_reset_midflight();
        test_x_time();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adc_quantizer
